exec_decode_unit: RTL and testbench

Combined main-control decoder, ALU-control decoder and 32-bit ALU for the five-stage MIPS pipeline, followed by one EX/MEM-style output register.
- Decodes the opcode and funct of the current instruction.
- Selects ALU operand B as either the register value or the sign-extended immediate.
- Computes the ALU result.
- Registers the result and the downstream control bits for the MEM stage.

---
 rtl/exec_decode_unit.sv | 194 +++++++++++++++++++
 tb/tb_exec_decode_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exec_decode_unit.sv
// EX stage for the 5-stage MIPS pipe: main control, ALU control, 32-bit ALU and the EX/MEM register.
// Build option: define ALU_SHIFT_EN to add sll/srl to the R-type funct decode.
module exec_decode_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic [31:0]  instr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         regdst,
  output logic         branch,
  output logic         memread,
  output logic         memwrite,
  output logic         memtoreg,
  output logic         regwrite,
  output logic         alusrc,
  output logic [1:0]   aluop,
  output logic [3:0]   aluctl,
  output logic [W-1:0] alu_out,
  output logic         zero,
  output logic [W-1:0] alu_out_q,
  output logic         zero_q,
  output logic         regwrite_q,
  output logic         memread_q,
  output logic         memwrite_q,
  output logic         memtoreg_q
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         regwrite;
    logic         memread;
    logic         memwrite;
    logic         memtoreg;
  } ex_mem_t;

  logic [5:0]   opcode, funct;
  logic [4:0]   shamt;
  logic [W-1:0] imm_sx, op_b;
  ex_mem_t      ex_d, ex_q;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign shamt  = instr[10:6];
  assign imm_sx = {{(W-16){instr[15]}}, instr[15:0]};

  // rs/rt/rd fields are resolved upstream; only the opcode/funct/imm/shamt matter here
`ifdef ALU_SHIFT_EN
  logic unused_fields;
  assign unused_fields = ^instr[25:16];
`else
  logic unused_fields;
  assign unused_fields = ^{instr[25:16], shamt};
`endif

  // main control
  always_comb begin
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        aluop    = 2'b10;
      end
      OP_LW: begin
        alusrc   = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        memread  = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluop  = 2'b01;
      end
      OP_ADDI: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control
  always_comb begin
    aluctl = ALU_ADD;
    case (aluop)
      2'b01: aluctl = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_XOR:  aluctl = ALU_XOR;
          FN_NOR:  aluctl = ALU_NOR;
          FN_SLT:  aluctl = ALU_SLT;
`ifdef ALU_SHIFT_EN
          FN_SLL:  aluctl = ALU_SLL;
          FN_SRL:  aluctl = ALU_SRL;
`endif
          default: aluctl = ALU_BAD;
        endcase
      end
      default: aluctl = ALU_ADD;
    endcase
  end

  assign op_b = alusrc ? imm_sx : b;

  // unlisted codes (incl. 1111) produce 0, which also raises zero
  always_comb begin
    alu_out = '0;
    case (aluctl)
      ALU_AND: alu_out = a & op_b;
      ALU_OR:  alu_out = a | op_b;
      ALU_ADD: alu_out = a + op_b;
      ALU_SUB: alu_out = a - op_b;
      ALU_XOR: alu_out = a ^ op_b;
      ALU_NOR: alu_out = ~(a | op_b);
      ALU_SLT: alu_out = {{(W-1){1'b0}}, ($signed(a) < $signed(op_b))};
`ifdef ALU_SHIFT_EN
      ALU_SLL: alu_out = op_b << shamt;
      ALU_SRL: alu_out = op_b >> shamt;
`endif
      default: alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

  assign ex_d = '{res:      alu_out,
                  zero:     zero,
                  regwrite: regwrite,
                  memread:  memread,
                  memwrite: memwrite,
                  memtoreg: memtoreg};

  // flush beats stall so a squashed slot never survives a hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ex_q <= '0;
    else if (flush)  ex_q <= '0;
    else if (!stall) ex_q <= ex_d;
  end

  assign alu_out_q  = ex_q.res;
  assign zero_q     = ex_q.zero;
  assign regwrite_q = ex_q.regwrite;
  assign memread_q  = ex_q.memread;
  assign memwrite_q = ex_q.memwrite;
  assign memtoreg_q = ex_q.memtoreg;

endmodule

// File: tb/tb_exec_decode_unit.sv
// Directed + randomized bench for exec_decode_unit against a mnemonic-level reference model.
module tb_exec_decode_unit;

  logic        clk, rst_n, stall, flush;
  logic [31:0] instr, a, b;
  logic        regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] alu_out, alu_out_q;
  logic        zero, zero_q, regwrite_q, memread_q, memwrite_q, memtoreg_q;

  int n_cmp = 0;
  int n_bad = 0;

  // expected registered state: {res, zero, regwrite, memread, memwrite, memtoreg}
  logic [31:0] exp_res_q;
  logic [4:0]  exp_bits_q;

  exec_decode_unit #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .instr(instr), .a(a), .b(b),
    .regdst(regdst), .branch(branch), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrc(alusrc),
    .aluop(aluop), .aluctl(aluctl), .alu_out(alu_out), .zero(zero),
    .alu_out_q(alu_out_q), .zero_q(zero_q), .regwrite_q(regwrite_q),
    .memread_q(memread_q), .memwrite_q(memwrite_q), .memtoreg_q(memtoreg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ctl = {regdst,branch,memread,memwrite,memtoreg,regwrite,alusrc,aluop[1:0]}
  function automatic void ref_eval(input logic [31:0] i, input logic [31:0] ra, input logic [31:0] rb,
                                   output logic [8:0] ctl, output logic [3:0] ac,
                                   output logic [31:0] res);
    logic [31:0] imm, opb;
    int sa, sb;
    imm = {{16{i[15]}}, i[15:0]};
    case (i[31:26])
      6'h00:   ctl = 9'b1_0_0_0_0_1_0_10;
      6'h23:   ctl = 9'b0_0_1_0_1_1_1_00;
      6'h2B:   ctl = 9'b0_0_0_1_0_0_1_00;
      6'h04:   ctl = 9'b0_1_0_0_0_0_0_01;
      6'h08:   ctl = 9'b0_0_0_0_0_1_1_00;
      default: ctl = 9'b0;
    endcase
    opb = ctl[2] ? imm : rb;
    sa = ra;
    sb = opb;
    ac = 4'b0010;
    res = ra + opb;
    if (i[31:26] == 6'h04) begin
      ac = 4'b0110; res = ra - opb;
    end else if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h20: begin ac = 4'b0010; res = ra + opb; end
        6'h22: begin ac = 4'b0110; res = ra - opb; end
        6'h24: begin ac = 4'b0000; res = ra & opb; end
        6'h25: begin ac = 4'b0001; res = ra | opb; end
        6'h26: begin ac = 4'b1101; res = ra ^ opb; end
        6'h27: begin ac = 4'b1100; res = ~(ra | opb); end
        6'h2A: begin ac = 4'b0111; res = (sa < sb) ? 32'd1 : 32'd0; end
`ifdef ALU_SHIFT_EN
        6'h00: begin ac = 4'b1000; res = opb << i[10:6]; end
        6'h02: begin ac = 4'b1001; res = opb >> i[10:6]; end
`endif
        default: begin ac = 4'b1111; res = 32'd0; end
      endcase
    end
  endfunction

  // one cycle: drive at negedge, check comb, clock, check register
  task automatic apply(input logic [31:0] ti, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic ts, input logic tf);
    logic [8:0]  ctl;
    logic [3:0]  ac;
    logic [31:0] res;
    @(negedge clk);
    instr = ti; a = ta; b = tb_; stall = ts; flush = tf;
    #1;
    ref_eval(ti, ta, tb_, ctl, ac, res);
    check("ctl", {23'd0, regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc, aluop},
          {23'd0, ctl});
    check("aluctl", {28'd0, aluctl}, {28'd0, ac});
    check("alu_out", alu_out, res);
    check("zero", {31'd0, zero}, {31'd0, (res == 32'd0)});
    if (!rst_n || tf) begin
      exp_res_q = 32'd0; exp_bits_q = 5'd0;
    end else if (!ts) begin
      exp_res_q  = res;
      exp_bits_q = {(res == 32'd0), ctl[3], ctl[6], ctl[5], ctl[4]};
    end
    @(posedge clk);
    #1;
    check("alu_out_q", alu_out_q, exp_res_q);
    check("q_bits", {27'd0, zero_q, regwrite_q, memread_q, memwrite_q, memtoreg_q},
          {27'd0, exp_bits_q});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] ops[6];
    logic [5:0] fns[10];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h11};
    r = $urandom;
    r[31:26] = ops[$urandom_range(5)];
    if ($urandom_range(7) == 0) r[31:26] = 6'($urandom);
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(9)];
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    instr = '0; a = '0; b = '0;
    exp_res_q = '0; exp_bits_q = '0;

    // reset held: register stays clear regardless of inputs
    repeat (3) apply($urandom, $urandom, $urandom, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add 5 + 7
    apply(32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0);
    check("plan_add_q", alu_out_q, 32'd12);
    check("plan_add_rw_q", {31'd0, regwrite_q}, 32'd1);

    // slt signed, sub to zero
    apply(32'h0022182A, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    check("plan_slt_q", alu_out_q, 32'd1);
    apply(32'h00221822, 32'd9, 32'd9, 1'b0, 1'b0);
    check("plan_sub_zero_q", {31'd0, zero_q}, 32'd1);

    // lw with negative offset
    apply(32'h8C22FFFC, 32'h100, 32'h5555, 1'b0, 1'b0);
    check("plan_lw_q", alu_out_q, 32'hFC);
    check("plan_lw_mem_q", {30'd0, memread_q, memtoreg_q}, 32'd3);

    // stall holds for two cycles while instr changes, then flush wins over stall
    apply(32'h00221824, $urandom, $urandom, 1'b1, 1'b0);
    apply(32'hAC220010, $urandom, $urandom, 1'b1, 1'b0);
    check("plan_stall_hold", alu_out_q, 32'hFC);
    apply(32'h00221825, $urandom, $urandom, 1'b1, 1'b1);
    check("plan_flush", {27'd0, zero_q, regwrite_q, memread_q, memwrite_q, memtoreg_q}, 32'd0);

    // unknown opcode: no control asserted
    apply(32'hFC000000, 32'd3, 32'd4, 1'b0, 1'b0);
    check("plan_unknown_ctl", {24'd0, regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc, aluop[0]},
          32'd0);

    // sll by 4 of b = 1
    apply(32'h00000100, 32'd0, 32'd1, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
    check("plan_sll_q", alu_out_q, 32'd16);
`else
    check("plan_sll_q", alu_out_q, 32'd0);
`endif

    // asynchronous reset mid-cycle clears the register immediately
    apply(32'h20220007, 32'd100, 32'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_res_q = '0; exp_bits_q = '0;
    check("async_rst_res", alu_out_q, 32'd0);
    check("async_rst_bits", {27'd0, zero_q, regwrite_q, memread_q, memwrite_q, memtoreg_q}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    apply(32'h20220007, 32'd100, 32'd0, 1'b0, 1'b0);
    check("rst_release_load", alu_out_q, 32'd107);

    // randomized traffic
    for (int k = 0; k < 300; k++)
      apply(rand_instr(), $urandom, $urandom,
            ($urandom_range(7) == 0), ($urandom_range(9) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
